if_fetch_ctrl: RTL and testbench
================================

IF_FETCH_CTRL -- requirements
Module: if_fetch_ctrl

Interface
REQ-001 Parameter MEM_WORDS, default 128, SHALL be the instruction memory depth in 32-bit words.
REQ-002 Parameter NOP, default 32'h00000000, SHALL be the instruction word inserted for bubbles.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 stall  input  1  SHALL be the hazard-unit hold request (hold PC and IF/ID).
REQ-006 redirect  input  1  SHALL be the taken-branch/jump request from the MEM stage.
REQ-007 redirect_pc  input  32  SHALL be the word-index target used when redirect=1.
REQ-008 imem_addr  output  32  SHALL be the word address driven to instruction memory.
REQ-009 imem_data  input  32  SHALL be the instruction word returned combinationally by memory for imem_addr.
REQ-010 if_id_instr  output  32  SHALL be the registered instruction presented to ID.
REQ-011 if_id_npc  output  32  SHALL be the registered PC+1 of that instruction.
REQ-012 if_id_valid  output  1  SHALL mark if_id_instr as a real instruction (0 = bubble).
REQ-013 fetch_fault  output  1  SHALL be a one-cycle registered pulse flagging an out-of-range fetch.
REQ-014 fetch_count  output  16  SHALL be the count of valid instructions latched into IF/ID.

Function
REQ-015 imem_addr SHALL equal the PC register combinationally, with no added latency.
REQ-016 Fetch latency SHALL be one cycle: imem_data sampled at edge N appears on if_id_instr after edge N.
REQ-017 Normal advance (stall=0, redirect=0, PC<MEM_WORDS): PC<=PC+1; if_id_instr<=imem_data; if_id_npc<=PC+1; if_id_valid<=1.
REQ-018 PC+1 SHALL be 32-bit modulo; 32'hFFFFFFFF advances to 0.
REQ-019 Stall (stall=1, redirect=0): PC, if_id_instr, if_id_npc, if_id_valid SHALL all hold; fetch_count SHALL hold.
REQ-020 Redirect SHALL take priority over stall: PC<=redirect_pc; if_id_instr<=NOP; if_id_npc<=0; if_id_valid<=0.
REQ-021 Out-of-range (PC>=MEM_WORDS, no redirect, no stall): if_id_instr<=NOP; if_id_valid<=0; if_id_npc<=PC+1; PC<=PC+1; fetch_fault<=1 next cycle.
REQ-022 Out-of-range with stall=1 SHALL hold state and raise no fetch_fault.
REQ-023 fetch_fault SHALL be 0 in every cycle not immediately following an REQ-021 event.
REQ-024 Controller states: RUN (advance), HOLD (stall), REDIRECT (bubble+load), FAULT (out-of-range bubble); state SHALL be chosen each cycle by priority redirect > stall > range check > run.
REQ-025 fetch_count SHALL increment by 1 on each edge where if_id_valid is written 1, and SHALL saturate at 16'hFFFF.
REQ-026 imem_data containing X/Z SHALL be latched unchanged; the block SHALL NOT interpret instruction contents.

Reset
REQ-027 rst_n=0 SHALL immediately, without a clock, force PC=0, if_id_instr=NOP, if_id_npc=0, if_id_valid=0, fetch_fault=0, fetch_count=0.
REQ-028 Reset asserted mid-stall or mid-redirect SHALL discard the pending operation.
REQ-029 First edge after rst_n rises SHALL fetch word 0 under the REQ-017 rules.

Verification
REQ-030 Reset release, memory words 0..2 = 32'h002300AA, 32'h10654321, 32'h00100022, three edges -> if_id_instr follows that sequence; if_id_npc = 1,2,3; fetch_count=3.
REQ-031 PC=4, stall=1 for 3 cycles -> imem_addr stays 4; IF/ID outputs and fetch_count unchanged; release -> word 4 latched, if_id_npc=5.
REQ-032 PC=6, redirect=1, redirect_pc=2, stall=1 same cycle -> next PC=2, if_id_valid=0, if_id_instr=NOP; following edge latches word 2.
REQ-033 Redirect to 127 (MEM_WORDS=128) -> word 127 latched valid; next cycle PC=128 -> bubble, fetch_fault pulses exactly one cycle, PC=129.
REQ-034 rst_n dropped asynchronously between edges while if_id_valid=1, PC=9 -> outputs reset within same cycle; PC=0.
REQ-035 fetch_count preloaded near saturation via 65535 valid fetches -> stays 16'hFFFF on further valid fetches; redirect_pc=32'hFFFFFFFF then advance -> PC wraps to 0.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC and the IF/ID pipeline register.
// Chooses redirect, hold, out-of-range bubble or normal advance every cycle.
//
// state    | meaning
// ---------+------------------------------------------------------------
// RUN      | in-range fetch: latch imem_data, PC advances
// HOLD     | stall: PC, IF/ID and fetch_count keep their values
// REDIRECT | load redirect_pc into the PC, insert a bubble into IF/ID
// FAULT    | PC beyond memory: insert a bubble, PC advances, pulse fault
module if_fetch_ctrl #(
  parameter int          MEM_WORDS = 128,
  parameter logic [31:0] NOP       = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_npc,
  output logic        if_id_valid,
  output logic        fetch_fault,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    HOLD     = 2'd1,
    REDIRECT = 2'd2,
    FAULT    = 2'd3
  } state_t;

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

  state_t      state, state_q;
  logic [31:0] pc, pc_nxt, pc_plus1;
  logic [31:0] instr_nxt, npc_nxt;
  logic        valid_nxt;
  logic [15:0] count_nxt;

  assign imem_addr   = pc;
  assign pc_plus1    = pc + 32'd1;
  // The previous cycle's decision is kept so the fault flag is a clean one-cycle pulse.
  assign fetch_fault = (state_q == FAULT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      pc          <= 32'd0;
      if_id_instr <= NOP;
      if_id_npc   <= 32'd0;
      if_id_valid <= 1'b0;
      fetch_count <= 16'd0;
    end else begin
      state_q     <= state;
      pc          <= pc_nxt;
      if_id_instr <= instr_nxt;
      if_id_npc   <= npc_nxt;
      if_id_valid <= valid_nxt;
      fetch_count <= count_nxt;
    end
  end

  always_comb begin
    state     = RUN;
    pc_nxt    = pc;
    instr_nxt = if_id_instr;
    npc_nxt   = if_id_npc;
    valid_nxt = if_id_valid;
    count_nxt = fetch_count;

    if (redirect)              state = REDIRECT;
    else if (stall)            state = HOLD;
    else if (pc >= MEM_LIMIT)  state = FAULT;
    else                       state = RUN;

    unique case (state)
      RUN: begin
        pc_nxt    = pc_plus1;
        instr_nxt = imem_data;
        npc_nxt   = pc_plus1;
        valid_nxt = 1'b1;
        if (fetch_count != 16'hFFFF) count_nxt = fetch_count + 16'd1;
      end
      HOLD: begin
      end
      REDIRECT: begin
        pc_nxt    = redirect_pc;
        instr_nxt = NOP;
        npc_nxt   = 32'd0;
        valid_nxt = 1'b0;
      end
      FAULT: begin
        pc_nxt    = pc_plus1;
        instr_nxt = NOP;
        npc_nxt   = pc_plus1;
        valid_nxt = 1'b0;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed vector bench for if_fetch_ctrl: table of single-cycle vectors plus
// hand sequences for async reset, counter saturation and PC wrap.
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_npc;
  logic        if_id_valid;
  logic        fetch_fault;
  logic [15:0] fetch_count;

  int applied = 0;
  int miscompares = 0;

  logic [31:0] mem [0:127];

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] npc;
    logic        valid;
    logic        fault;
    logic [15:0] cnt;
  } vec_t;

  vec_t vec [18];

  if_fetch_ctrl #(.MEM_WORDS(128), .NOP(32'h00000000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .if_id_instr (if_id_instr),
    .if_id_npc   (if_id_npc),
    .if_id_valid (if_id_valid),
    .fetch_fault (fetch_fault),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  assign imem_data = (imem_addr < 32'd128) ? mem[imem_addr[6:0]] : 32'hDEADBEEF;

  function automatic vec_t mk(logic s, logic r, logic [31:0] rpc, logic [31:0] pc,
                              logic [31:0] instr, logic [31:0] npc, logic v,
                              logic f, logic [15:0] c);
    vec_t t;
    t.stall = s; t.redirect = r; t.rpc = rpc; t.pc = pc; t.instr = instr;
    t.npc = npc; t.valid = v; t.fault = f; t.cnt = c;
    return t;
  endfunction

  task automatic check(string name, vec_t e);
    applied++;
    if (imem_addr !== e.pc || if_id_instr !== e.instr || if_id_npc !== e.npc ||
        if_id_valid !== e.valid || fetch_fault !== e.fault || fetch_count !== e.cnt) begin
      miscompares++;
      $display("FAIL %s: got pc=%h instr=%h npc=%h valid=%b fault=%b cnt=%h, want pc=%h instr=%h npc=%h valid=%b fault=%b cnt=%h",
               name, imem_addr, if_id_instr, if_id_npc, if_id_valid, fetch_fault, fetch_count,
               e.pc, e.instr, e.npc, e.valid, e.fault, e.cnt);
    end
  endtask

  task automatic step(logic s, logic r, logic [31:0] rpc);
    stall = s; redirect = r; redirect_pc = rpc;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int exp_cnt;
    int fetched;
    int cycles;
    logic redir;

    for (int i = 0; i < 128; i++) mem[i] = 32'hC0DE0000 | i;
    mem[0] = 32'h002300AA;
    mem[1] = 32'h10654321;
    mem[2] = 32'h00100022;

    vec[0]  = mk(0, 0, 0,   1,   32'h002300AA, 1,   1, 0, 1);
    vec[1]  = mk(0, 0, 0,   2,   32'h10654321, 2,   1, 0, 2);
    vec[2]  = mk(0, 0, 0,   3,   32'h00100022, 3,   1, 0, 3);
    vec[3]  = mk(0, 0, 0,   4,   32'hC0DE0003, 4,   1, 0, 4);
    vec[4]  = mk(1, 0, 0,   4,   32'hC0DE0003, 4,   1, 0, 4);
    vec[5]  = mk(1, 0, 0,   4,   32'hC0DE0003, 4,   1, 0, 4);
    vec[6]  = mk(1, 0, 0,   4,   32'hC0DE0003, 4,   1, 0, 4);
    vec[7]  = mk(0, 0, 0,   5,   32'hC0DE0004, 5,   1, 0, 5);
    vec[8]  = mk(0, 0, 0,   6,   32'hC0DE0005, 6,   1, 0, 6);
    vec[9]  = mk(1, 1, 2,   2,   32'h00000000, 0,   0, 0, 6);
    vec[10] = mk(0, 0, 0,   3,   32'h00100022, 3,   1, 0, 7);
    vec[11] = mk(0, 1, 127, 127, 32'h00000000, 0,   0, 0, 7);
    vec[12] = mk(0, 0, 0,   128, 32'hC0DE007F, 128, 1, 0, 8);
    vec[13] = mk(0, 0, 0,   129, 32'h00000000, 129, 0, 1, 8);
    vec[14] = mk(1, 0, 0,   129, 32'h00000000, 129, 0, 0, 8);
    vec[15] = mk(0, 0, 0,   130, 32'h00000000, 130, 0, 1, 8);
    vec[16] = mk(0, 1, 8,   8,   32'h00000000, 0,   0, 0, 8);
    vec[17] = mk(0, 0, 0,   9,   32'hC0DE0008, 9,   1, 0, 9);

    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    repeat (2) @(negedge clk);
    check("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      step(vec[i].stall, vec[i].redirect, vec[i].rpc);
      check($sformatf("vec%0d", i), vec[i]);
    end

    // Asynchronous reset between edges while IF/ID holds a valid word at PC=9.
    stall = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("async_reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("reset_during_stall", mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;

    // Saturation: keep PC inside memory by looping back from 127 to 0.
    exp_cnt = 0;
    fetched = 0;
    cycles  = 0;
    while (fetched < 65538 && cycles < 80000) begin
      redir = (imem_addr == 32'd127);
      step(0, redir, 32'd0);
      cycles++;
      if (!redir) begin
        fetched++;
        if (exp_cnt < 65535) exp_cnt++;
      end
      if (fetched == 65535 && !redir) begin
        applied++;
        if (fetch_count !== 16'(exp_cnt)) begin
          miscompares++;
          $display("FAIL sat_reach: got cnt=%h, want %h", fetch_count, 16'(exp_cnt));
        end
      end
    end
    applied++;
    if (fetched < 65538) begin
      miscompares++;
      $display("FAIL sat_budget: got %0d fetches, want 65538", fetched);
    end
    if (fetch_count !== 16'hFFFF || if_id_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_hold: got cnt=%h valid=%b, want cnt=ffff valid=1", fetch_count, if_id_valid);
    end

    // PC wrap from 32'hFFFFFFFF: the advance itself is an out-of-range fetch.
    step(0, 1, 32'hFFFFFFFF);
    check("wrap_redirect", mk(0, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 16'hFFFF));
    step(0, 0, 0);
    check("wrap_advance", mk(0, 0, 0, 0, 0, 0, 0, 1, 16'hFFFF));
    step(0, 0, 0);
    check("wrap_fetch0", mk(0, 0, 0, 1, 32'h002300AA, 1, 1, 0, 16'hFFFF));

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
